mc_core: RTL and testbench
==========================

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter WIDTH, default 32, datapath/register/address width; legal values 32 or 64.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset; word-aligned.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 mem_req  out  1  memory access request, held until accepted.
REQ-007 mem_we  out  1  1 = store, 0 = load/fetch; valid while mem_req=1.
REQ-008 mem_addr  out  WIDTH  byte address of the access.
REQ-009 mem_wdata  out  WIDTH  store data, registered rt value.
REQ-010 mem_rdata  in  WIDTH  read data, sampled on the accepting edge; instruction = bits [31:0].
REQ-011 mem_ready  in  1  access completes on the rising edge where mem_req=1 and mem_ready=1.
REQ-012 pc  out  WIDTH  current program counter.
REQ-013 state_o  out  4  current FSM state encoding, for debug.

Function
REQ-014 Multicycle MIPS subset: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw (23), sw (2B), beq (04), addi (08), j (02); all other opcodes SHALL execute as NOP (DECODE->FETCH).
REQ-015 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on acceptance IR<=mem_rdata[31:0], pc<=pc+4, next DECODE; without acceptance stay in FETCH with all outputs stable.
REQ-017 DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(signimm<<2); next state by opcode.
REQ-018 MEMADR: ALUOut<=A+signimm; next MEMRD (lw) or MEMWR (sw).
REQ-019 MEMRD: mem_req=1, mem_we=0, mem_addr=ALUOut; on acceptance MDR<=mem_rdata, next MEMWB; MEMWB: rf[rt]<=MDR, next FETCH.
REQ-020 MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B; on acceptance next FETCH.
REQ-021 EXEC: ALUOut<=A op B; ALUWB: rf[rd]<=ALUOut; then FETCH.
REQ-022 BRANCH: if A==B then pc<=ALUOut; next FETCH.
REQ-023 ADDIEX: ALUOut<=A+signimm; ADDIWB: rf[rt]<=ALUOut; then FETCH.
REQ-024 Immediates SHALL sign-extend from bit 15 to WIDTH; arithmetic wraps modulo 2^WIDTH; slt is signed, result 1 or 0.
REQ-025 Register file 32 x WIDTH, two async read ports, one write port; r0 SHALL read 0 and ignore writes.
REQ-026 mem_req SHALL be 0 in all states other than FETCH, MEMRD, MEMWR.
REQ-027 Latency with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-028 On reset_n=0, immediately: state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, mem_req=0 while reset asserted; register file contents not reset.
REQ-029 Reset asserted mid-access SHALL abandon the access; no register or pc update from it.
REQ-030 First fetch request SHALL appear in the cycle after reset_n deasserts.

Configuration
REQ-031 Macro MC_CORE_JUMP_EN defined: j (02) enters JUMP, pc<={pc[WIDTH-1:28], IR[25:0], 2'b00}, next FETCH.
REQ-032 MC_CORE_JUMP_EN undefined: opcode 02 SHALL execute as NOP; no JUMP state logic present.

Verification
REQ-033 Reset, mem_ready=1, memory 0: addi $1,$0,5 -> after 4 cycles rf[1]=5, pc=4.
REQ-034 rf[1]=5, rf[2]=7, add $3,$1,$2 then slt $4,$2,$1 -> rf[3]=12, rf[4]=0; sub $5,$1,$2 -> rf[5]=FFFFFFFE (WIDTH=32).
REQ-035 sw $3,8($0) with mem_ready low 3 cycles -> mem_req/mem_addr=8/mem_wdata=12 stable 4 cycles; lw $6,8($0) -> rf[6]=12.
REQ-036 beq $1,$1,-1 at pc=0x10 -> pc=0x10 after 3 cycles; beq $1,$2 (unequal) -> pc=0x14.
REQ-037 reset_n pulsed low during MEMRD with mem_ready=0 -> mem_req=0 at once, pc=RESET_PC, target register unchanged.
REQ-038 j 0x40 at pc=0: with MC_CORE_JUMP_EN pc=0x100 after 3 cycles; without it pc=4 after 2 cycles; addi $0,$0,9 -> rf[0] reads 0.

Source files
------------

// File: rtl/mc_core.sv
// Multicycle MIPS-subset core: one memory port with req/ready handshake, held until accepted.
// Optional j instruction is built only when MC_CORE_JUMP_EN is defined; otherwise opcode 02 is a NOP.
module mc_core #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
`ifdef MC_CORE_JUMP_EN
    S_JUMP   = 4'd11,
`endif
    S_ADDIWB = 4'd10
  } state_t;

  state_t           state;
  state_t           dec_state;
  logic [31:0]      ir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] aluout;
  logic [WIDTH-1:0] mdr;
  logic [WIDTH-1:0] rf [32];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] signimm;
  logic [WIDTH-1:0] alu_y;
  logic             funct_ok;
  logic             accept;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;

  assign signimm   = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign rd_a      = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
  assign rd_b      = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
  assign accept    = mem_req && mem_ready;
  assign mem_addr  = (state == S_MEMRD || state == S_MEMWR) ? aluout : pc;
  assign mem_wdata = b;
  assign state_o   = state;

  assign funct_ok = (ir[5:0] == 6'h20) || (ir[5:0] == 6'h22) || (ir[5:0] == 6'h24) ||
                    (ir[5:0] == 6'h25) || (ir[5:0] == 6'h2A);

  always_comb begin
    dec_state = S_FETCH;
    case (ir[31:26])
      6'h00:        if (funct_ok) dec_state = S_EXEC;
      6'h23, 6'h2B: dec_state = S_MEMADR;
      6'h04:        dec_state = S_BRANCH;
      6'h08:        dec_state = S_ADDIEX;
`ifdef MC_CORE_JUMP_EN
      6'h02:        dec_state = S_JUMP;
`endif
      default:      dec_state = S_FETCH;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (ir[5:0])
      6'h20:   alu_y = a + b;
      6'h22:   alu_y = a - b;
      6'h24:   alu_y = a & b;
      6'h25:   alu_y = a | b;
      6'h2A:   alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_y = '0;
    endcase
  end

  // Write-back happens only in the three *WB states, so a reset abandons any pending result.
  always_comb begin
    rf_we = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB);
    rf_wa = (state == S_ALUWB) ? ir[15:11] : ir[20:16];
    rf_wd = (state == S_MEMWB) ? mdr : aluout;
  end

  always_ff @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
  end

  // mem_req/mem_we are registered alongside the state so the bus never glitches;
  // out of reset mem_req rises one cycle late, which is the first fetch request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      aluout  <= '0;
      mdr     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (accept) begin
            ir      <= mem_rdata[31:0];
            pc      <= pc + WIDTH'(4);
            state   <= S_DECODE;
            mem_req <= 1'b0;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          a       <= rd_a;
          b       <= rd_b;
          aluout  <= pc + (signimm << 2);
          state   <= dec_state;
          mem_req <= (dec_state == S_FETCH);
        end
        S_MEMADR: begin
          aluout  <= a + signimm;
          mem_req <= 1'b1;
          if (ir[31:26] == 6'h2B) begin
            state  <= S_MEMWR;
            mem_we <= 1'b1;
          end else begin
            state  <= S_MEMRD;
          end
        end
        S_MEMRD: begin
          if (accept) begin
            mdr     <= mem_rdata;
            state   <= S_MEMWB;
            mem_req <= 1'b0;
          end
        end
        S_MEMWB: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_MEMWR: begin
          if (accept) begin
            state  <= S_FETCH;
            mem_we <= 1'b0;
          end
        end
        S_EXEC: begin
          aluout <= alu_y;
          state  <= S_ALUWB;
        end
        S_ALUWB: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_BRANCH: begin
          if (a == b) pc <= aluout;
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_ADDIEX: begin
          aluout <= a + signimm;
          state  <= S_ADDIWB;
        end
        S_ADDIWB: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
`ifdef MC_CORE_JUMP_EN
        S_JUMP: begin
          pc      <= {pc[WIDTH-1:28], ir[25:0], 2'b00};
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
`endif
        default: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Bench for mc_core: memory model, store scoreboard, instruction table plus stall/reset/jump sequences.
module tb_mc_core;

  logic        clk;
  logic        reset_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic [3:0]  state_o;

  mc_core #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .state_o(state_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  typedef struct {
    int          c;
    logic [31:0] a;
  } fr_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          lat;
    logic [31:0] nxt;
  } vec_t;

  logic [31:0] mem [128];
  st_t  sb [$];
  fr_t  fq [$];
  vec_t vt [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   fetch_mon = 0;
  bit   st_block = 0;
  bit   ld_block = 0;

  assign mem_rdata = mem[mem_addr[8:2]];
  assign mem_ready = !((mem_req && mem_we && st_block) ||
                       (mem_req && !mem_we && ld_block && mem_addr == 32'h80));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stores are scored as they complete; fetches are time-stamped for latency checks.
  always @(negedge clk) begin
    if (reset_n && mem_req && mem_ready) begin
      if (mem_we) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL st_unexpected actual=%0h:%0h required=none", mem_addr, mem_wdata);
        end else begin
          st_t e;
          e = sb.pop_front();
          check("st_addr", mem_addr, e.addr);
          check("st_data", mem_wdata, e.data);
        end
        mem[mem_addr[8:2]] = mem_wdata;
      end else if (fetch_mon && mem_addr < 32'h80) begin
        fr_t f;
        f.c = cyc;
        f.a = mem_addr;
        fq.push_back(f);
      end
    end
  end

  function automatic logic [31:0] iti(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rty(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic addv(input logic [31:0] p, input logic [31:0] ins, input int lat,
                      input logic [31:0] nxt);
    vec_t v;
    v.pc = p; v.ins = ins; v.lat = lat; v.nxt = nxt;
    vt.push_back(v);
    mem[p[8:2]] = ins;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_acc(input bit we, input logic [31:0] a, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(mem_req && mem_we == we && mem_addr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=access@%0h", nm, a);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(nm, sb.size(), 0);
  endtask

  localparam logic [15:0] M1 = 16'hFFFF;

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    // Instruction table in execution order: {pc, instruction, latency, next fetch address}.
    addv(32'h00, iti(6'h08, 0, 1, 16'd5), 4, 32'h04);
    addv(32'h04, iti(6'h08, 0, 2, 16'd7), 4, 32'h08);
    addv(32'h08, rty(1, 2, 3, 6'h20), 4, 32'h0C);
    addv(32'h0C, rty(2, 1, 4, 6'h2A), 4, 32'h10);
    addv(32'h10, rty(1, 2, 5, 6'h22), 4, 32'h14);
    addv(32'h14, rty(1, 2, 6, 6'h24), 4, 32'h18);
    addv(32'h18, rty(1, 2, 7, 6'h25), 4, 32'h1C);
    addv(32'h1C, rty(1, 2, 8, 6'h2A), 4, 32'h20);
    addv(32'h20, iti(6'h08, 0, 9, 16'hFFFD), 4, 32'h24);
    addv(32'h24, iti(6'h2B, 0, 3, 16'h80), 4, 32'h28); push_st(32'h80, 32'd12);
    addv(32'h28, iti(6'h2B, 0, 4, 16'h84), 4, 32'h2C); push_st(32'h84, 32'd0);
    addv(32'h2C, iti(6'h2B, 0, 5, 16'h88), 4, 32'h30); push_st(32'h88, 32'hFFFFFFFE);
    addv(32'h30, iti(6'h2B, 0, 6, 16'h8C), 4, 32'h34); push_st(32'h8C, 32'd5);
    addv(32'h34, iti(6'h2B, 0, 7, 16'h90), 4, 32'h38); push_st(32'h90, 32'd7);
    addv(32'h38, iti(6'h2B, 0, 8, 16'h94), 4, 32'h3C); push_st(32'h94, 32'd1);
    addv(32'h3C, iti(6'h2B, 0, 9, 16'h98), 4, 32'h40); push_st(32'h98, 32'hFFFFFFFD);
    addv(32'h40, iti(6'h23, 0, 10, 16'h80), 5, 32'h44);
    addv(32'h44, iti(6'h2B, 0, 10, 16'h9C), 4, 32'h48); push_st(32'h9C, 32'd12);
    addv(32'h48, iti(6'h08, 0, 0, 16'd9), 4, 32'h4C);
    addv(32'h4C, iti(6'h2B, 0, 0, 16'hA0), 4, 32'h50); push_st(32'hA0, 32'd0);
    addv(32'h50, iti(6'h04, 1, 2, 16'd5), 3, 32'h54);
    addv(32'h54, iti(6'h04, 1, 1, 16'd1), 3, 32'h5C);
    addv(32'h5C, 32'hFC000000, 2, 32'h60);
    addv(32'h60, iti(6'h2B, 0, 1, 16'hA4), 4, 32'h64); push_st(32'hA4, 32'd5);
    addv(32'h64, iti(6'h04, 0, 0, M1), 3, 32'h64);
    mem[32'h58 >> 2] = iti(6'h08, 0, 1, 16'd99);

    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_pc", pc, 32'h0);
    fetch_mon = 1;
    reset_n = 1'b1;
    #1;
    check("rel_mem_req_low", mem_req, 1'b0);
    @(negedge clk);
    check("first_fetch_req", mem_req, 1'b1);
    check("first_fetch_we", mem_we, 1'b0);
    check("first_fetch_addr", mem_addr, 32'h0);

    for (int n = 0; n < 1000 && fq.size() < vt.size() + 1; n++) @(negedge clk);
    fetch_mon = 0;
    check("table_fetches", fq.size() >= vt.size() + 1, 1'b1);
    if (fq.size() >= vt.size() + 1) begin
      check("table_start_pc", fq[0].a, 32'h0);
      for (int i = 0; i < vt.size(); i++) begin
        check($sformatf("lat@%0h", vt[i].pc), fq[i+1].c - fq[i].c, vt[i].lat);
        check($sformatf("next@%0h", vt[i].pc), fq[i+1].a, vt[i].nxt);
      end
    end
    drain("table_stores");

    // Stalled store held stable, then lw reads it back; beq-to-self at 0x10.
    hold_reset();
    mem[0] = iti(6'h2B, 0, 3, 16'd8);
    mem[1] = iti(6'h23, 0, 6, 16'd8);
    mem[3] = iti(6'h2B, 0, 6, 16'h90);
    mem[4] = iti(6'h04, 1, 1, M1);
    push_st(32'h8, 32'd12);
    push_st(32'h90, 32'd12);
    st_block = 1;
    release_reset();
    wait_acc(1'b1, 32'h8, "st_stall_wait");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_req%0d", k), mem_req, 1'b1);
      check($sformatf("stall_we%0d", k), mem_we, 1'b1);
      check($sformatf("stall_addr%0d", k), mem_addr, 32'h8);
      check($sformatf("stall_wdata%0d", k), mem_wdata, 32'd12);
      if (k == 2) begin
        @(posedge clk);
        #1 st_block = 0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    check("after_store_we", mem_we, 1'b0);
    wait_acc(1'b0, 32'h10, "beq_fetch");
    @(negedge clk);
    check("beq_pc_inc", pc, 32'h14);
    repeat (2) @(negedge clk);
    check("beq_pc_back", pc, 32'h10);
    check("beq_refetch_req", mem_req, 1'b1);
    check("beq_refetch_addr", mem_addr, 32'h10);
    drain("lw_sw_stores");

    // Reset during a stalled load abandons it; $6 keeps its old value.
    hold_reset();
    mem[0] = iti(6'h23, 0, 6, 16'h80);
    mem[32] = 32'h55;
    ld_block = 1;
    release_reset();
    wait_acc(1'b0, 32'h80, "ld_wait");
    #1 reset_n = 1'b0;
    #1;
    check("abandon_req", mem_req, 1'b0);
    check("abandon_pc", pc, 32'h0);
    hold_reset();
    ld_block = 0;
    mem[0] = iti(6'h2B, 0, 6, 16'h94);
    mem[1] = iti(6'h04, 0, 0, M1);
    push_st(32'h94, 32'd12);
    release_reset();
    drain("abandon_store");

    // j 0x40 at pc 0.
    hold_reset();
    mem[0]  = {6'h02, 26'h40};
    mem[1]  = iti(6'h2B, 0, 1, 16'hA8);
    mem[2]  = iti(6'h04, 0, 0, M1);
    mem[64] = iti(6'h2B, 0, 2, 16'hA8);
    mem[65] = iti(6'h04, 0, 0, M1);
`ifdef MC_CORE_JUMP_EN
    push_st(32'hA8, 32'd7);
`else
    push_st(32'hA8, 32'd5);
`endif
    release_reset();
    wait_acc(1'b0, 32'h0, "j_fetch");
`ifdef MC_CORE_JUMP_EN
    repeat (3) @(negedge clk);
    check("j_pc", pc, 32'h100);
    check("j_fetch_addr", mem_addr, 32'h100);
`else
    repeat (2) @(negedge clk);
    check("j_nop_pc", pc, 32'h4);
    check("j_nop_fetch_addr", mem_addr, 32'h4);
`endif
    check("j_fetch_req", mem_req, 1'b1);
    drain("j_store");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
